// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: serve/rally/point/pause/game-over sequencer with scoring and win detection
module pong_match_ctrl #(
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 5,
  parameter int WIN_MARGIN  = 1,
  parameter int SERVE_TICKS = 1000,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               pause,
  input  logic               point_p1,
  input  logic               point_p2,
  output logic               round_rst,
  output logic               ball_en,
  output logic [SCORE_W-1:0] score_1,
  output logic [SCORE_W-1:0] score_2,
  output logic               serve_dir,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic [2:0]         state
);
  typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, POINT = 3'd3, PAUSED = 3'd4, OVER = 3'd5} state_t;
  localparam logic [SCORE_W:0] WS = (SCORE_W+1)'(WIN_SCORE);
  localparam logic [SCORE_W:0] MG = (SCORE_W+1)'(WIN_MARGIN);
  localparam logic [CNT_W-1:0] ST = CNT_W'(SERVE_TICKS);
  state_t st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SCORE_W-1:0] s1_n, s2_n;
  logic [SCORE_W:0] e1, e2;
  logic dir_n, w1, w2;
  logic [1:0] win_n;
  assign state = st;
  always_comb begin
    e1 = {1'b0, score_1};
    e2 = {1'b0, score_2};
    w1 = (e1 >= WS && e1 >= e2 + MG) || score_1 == '1;
    w2 = (e2 >= WS && e2 >= e1 + MG) || score_2 == '1;
    st_n = st;
    cnt_n = cnt;
    s1_n = score_1;
    s2_n = score_2;
    dir_n = serve_dir;
    win_n = winner;
    case (st)
      IDLE: if (start) begin
        st_n = SERVE;
        cnt_n = ST;
      end
      SERVE: if (cnt == '0) st_n = PLAY;
        else if (tick) cnt_n = cnt - 1'b1;
      PLAY: if (point_p1 && !point_p2) begin
        s1_n = score_1 == '1 ? score_1 : score_1 + 1'b1;
        dir_n = 1'b1;
        st_n = POINT;
      end else if (point_p2 && !point_p1) begin
        s2_n = score_2 == '1 ? score_2 : score_2 + 1'b1;
        dir_n = 1'b0;
        st_n = POINT;
      end else if (point_p1 && point_p2) st_n = POINT;
        else if (pause) st_n = PAUSED;
      PAUSED: if (pause) st_n = PLAY;
      POINT: if (w1) begin
        st_n = OVER;
        win_n = 2'b01;
      end else if (w2) begin
        st_n = OVER;
        win_n = 2'b10;
      end else begin
        st_n = SERVE;
        cnt_n = ST;
      end
      OVER: if (start) begin
        s1_n = '0;
        s2_n = '0;
        win_n = 2'b00;
        dir_n = 1'b0;
        st_n = SERVE;
        cnt_n = ST;
      end
      default: st_n = IDLE;
    endcase
  end
  // outputs are decoded from the next state so they change on the same edge as state
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      score_1 <= '0;
      score_2 <= '0;
      serve_dir <= 1'b0;
      winner <= 2'b00;
      round_rst <= 1'b1;
      ball_en <= 1'b0;
      game_over <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      score_1 <= s1_n;
      score_2 <= s2_n;
      serve_dir <= dir_n;
      winner <= win_n;
      round_rst <= !(st_n == PLAY || st_n == PAUSED);
      ball_en <= st_n == PLAY;
      game_over <= st_n == OVER;
    end
  end
endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: directed checks on two configurations (serve countdown/defaults, and win-by-2)
module tb_pong_match_ctrl;
  logic clk = 0, rst = 1;
  logic tick_a = 0, start_a = 0, pause_a = 0, p1_a = 0, p2_a = 0;
  logic tick_b = 0, start_b = 0, pause_b = 0, p1_b = 0, p2_b = 0;
  logic rr_a, be_a, dir_a, go_a, rr_b, be_b, dir_b, go_b;
  logic [3:0] s1_a, s2_a, s1_b, s2_b;
  logic [1:0] win_a, win_b;
  logic [2:0] st_a, st_b;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  pong_match_ctrl #(.SERVE_TICKS(3)) u_a (
    .clk(clk), .rst(rst), .tick(tick_a), .start(start_a), .pause(pause_a),
    .point_p1(p1_a), .point_p2(p2_a), .round_rst(rr_a), .ball_en(be_a),
    .score_1(s1_a), .score_2(s2_a), .serve_dir(dir_a), .game_over(go_a),
    .winner(win_a), .state(st_a));
  pong_match_ctrl #(.WIN_SCORE(3), .WIN_MARGIN(2), .SERVE_TICKS(0)) u_b (
    .clk(clk), .rst(rst), .tick(tick_b), .start(start_b), .pause(pause_b),
    .point_p1(p1_b), .point_p2(p2_b), .round_rst(rr_b), .ball_en(be_b),
    .score_1(s1_b), .score_2(s2_b), .serve_dir(dir_b), .game_over(go_b),
    .winner(win_b), .state(st_b));
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic edge_();
    @(posedge clk);
    #1;
    {tick_a, start_a, pause_a, p1_a, p2_a} = '0;
    {tick_b, start_b, pause_b, p1_b, p2_b} = '0;
  endtask
  task automatic chk_reset_a();
    chk("rst_state", 8'(st_a), 8'd0);
    chk("rst_round_rst", 8'(rr_a), 8'd1);
    chk("rst_ball_en", 8'(be_a), 8'd0);
    chk("rst_scores", {s1_a, s2_a}, 8'h00);
    chk("rst_dir", 8'(dir_a), 8'd0);
    chk("rst_over", {go_a, win_a}, 8'd0);
  endtask
  task automatic serve_a();
    for (int k = 0; k < 3; k++) begin
      tick_a = 1;
      edge_();
    end
    edge_();
    chk("serve_to_play", 8'(st_a), 8'd2);
  endtask
  task automatic point_b(input logic a, input logic b, input logic [2:0] exp_st);
    p1_b = a;
    p2_b = b;
    edge_();
    chk("b_point_state", 8'(st_b), 8'd3);
    edge_();
    chk("b_after_point", 8'(st_b), 8'(exp_st));
    if (exp_st == 3'd1) edge_();
  endtask
  initial begin
    edge_();
    edge_();
    rst = 0;
    chk_reset_a();
    start_a = 1;
    edge_();
    chk("start_serve", 8'(st_a), 8'd1);
    chk("serve_rr", {rr_a, be_a}, 8'b10);
    for (int k = 0; k < 3; k++) begin
      repeat (4) edge_();
      tick_a = 1;
      edge_();
    end
    chk("cnt0_still_serve", 8'(st_a), 8'd1);
    chk("cnt0_ball_off", 8'(be_a), 8'd0);
    edge_();
    chk("play_state", 8'(st_a), 8'd2);
    chk("play_rr_be", {rr_a, be_a}, 8'b01);
    p1_a = 1;
    edge_();
    chk("p1_point_state", 8'(st_a), 8'd3);
    chk("p1_score", {s1_a, s2_a}, 8'h10);
    chk("p1_dir", 8'(dir_a), 8'd1);
    chk("point_rr_be", {rr_a, be_a}, 8'b10);
    edge_();
    chk("point_to_serve", 8'(st_a), 8'd1);
    serve_a();
    p1_a = 1;
    p2_a = 1;
    edge_();
    chk("both_point_state", 8'(st_a), 8'd3);
    chk("both_scores", {s1_a, s2_a}, 8'h10);
    chk("both_dir", 8'(dir_a), 8'd1);
    edge_();
    chk("both_to_serve", 8'(st_a), 8'd1);
    serve_a();
    pause_a = 1;
    edge_();
    chk("paused_state", 8'(st_a), 8'd4);
    chk("paused_rr_be", {rr_a, be_a}, 8'b00);
    p1_a = 1;
    edge_();
    chk("paused_ignore_pt", {1'b0, st_a, s1_a}, {1'b0, 3'd4, 4'd1});
    pause_a = 1;
    edge_();
    chk("unpause", {st_a, be_a}, {3'd2, 1'b1});
    for (int i = 0; i < 4; i++) begin
      p1_a = 1;
      edge_();
      edge_();
      if (i < 3) begin
        chk("no_win_yet", 8'(st_a), 8'd1);
        serve_a();
      end
    end
    chk("over_state", 8'(st_a), 8'd5);
    chk("over_flags", {go_a, win_a}, 8'b101);
    chk("over_scores", {s1_a, s2_a}, 8'h50);
    chk("over_rr_be", {rr_a, be_a}, 8'b10);
    edge_();
    chk("over_held", {go_a, win_a, s1_a}, {3'b101, 4'd5});
    start_a = 1;
    edge_();
    chk("restart_state", 8'(st_a), 8'd1);
    chk("restart_scores", {s1_a, s2_a}, 8'h00);
    chk("restart_flags", {go_a, win_a, dir_a}, 8'd0);
    serve_a();
    pause_a = 1;
    edge_();
    chk("pause_again", 8'(st_a), 8'd4);
    rst = 1;
    p1_a = 1;
    edge_();
    rst = 0;
    chk_reset_a();
    start_b = 1;
    edge_();
    chk("b_serve", 8'(st_b), 8'd1);
    edge_();
    chk("b_serve0_play", 8'(st_b), 8'd2);
    for (int i = 0; i < 3; i++) begin
      point_b(1, 0, 3'd1);
      point_b(0, 1, 3'd1);
    end
    chk("b_tied", {s1_b, s2_b}, 8'h33);
    point_b(0, 1, 3'd1);
    chk("b_3_4_nowin", {go_b, win_b}, 8'd0);
    chk("b_3_4_scores", {s1_b, s2_b}, 8'h34);
    point_b(0, 1, 3'd5);
    chk("b_win_p2", {go_b, win_b}, 8'b110);
    chk("b_final_scores", {s1_b, s2_b}, 8'h35);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
